// File: rtl/pwm_decoder.sv
// Four-slot PWM frame decoder: measures the leading high-time of each slot,
// checks slot shape, and delivers all four duties together once per frame.
module pwm_decoder #(
   parameter int SLOT_LEN = 4,
   parameter int CW       = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pwm_in,
   input  logic          sync,
   output logic [CW-1:0] duty0,
   output logic [CW-1:0] duty1,
   output logic [CW-1:0] duty2,
   output logic [CW-1:0] duty3,
   output logic          frame_valid,
   output logic          slot_err,
   output logic          sync_err,
   output logic          locked
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [1:0]    s;
   logic [3:0]    p;
   logic [CW-1:0] hi_cnt;
   logic          zero_seen;
   logic          bad;
   logic [CW-1:0] staging0, staging1, staging2;
   logic [2:0]    bad_flags;

   logic          active;
   logic          restart;
   logic          last;
   logic [1:0]    cur_s;
   logic [3:0]    cur_p;
   logic [CW-1:0] hi_new;
   logic          zero_base;
   logic          bad_new;

   // A sync always pins the current sample to slot 0 position 0; when it
   // arrives off-boundary in RUN the partial frame is abandoned.
   always_comb begin
      active    = (state == RUN) || sync;
      restart   = (state == RUN) && sync && ((s != 2'd0) || (p != 4'd0));
      cur_s     = sync ? 2'd0 : s;
      cur_p     = sync ? 4'd0 : p;
      zero_base = (cur_p == 4'd0) ? 1'b0 : zero_seen;
      hi_new    = ((cur_p == 4'd0) ? '0 : hi_cnt) + {{(CW-1){1'b0}}, pwm_in};
      bad_new   = ((cur_p == 4'd0) ? 1'b0 : bad) | (pwm_in & zero_base);
      last      = (cur_p == 4'(SLOT_LEN - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         s           <= '0;
         p           <= '0;
         hi_cnt      <= '0;
         zero_seen   <= 1'b0;
         bad         <= 1'b0;
         staging0    <= '0;
         staging1    <= '0;
         staging2    <= '0;
         bad_flags   <= '0;
         duty0       <= '0;
         duty1       <= '0;
         duty2       <= '0;
         duty3       <= '0;
         frame_valid <= 1'b0;
         slot_err    <= 1'b0;
         sync_err    <= 1'b0;
         locked      <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= restart;
         if (active) begin
            state  <= RUN;
            locked <= 1'b1;
            if (last) begin
               hi_cnt    <= '0;
               zero_seen <= 1'b0;
               bad       <= 1'b0;
               p         <= 4'd0;
               s         <= cur_s + 2'd1;
               // Slot 3 bypasses staging so the frame is delivered on its last sample.
               case (cur_s)
                  2'd0: begin staging0 <= hi_new; bad_flags[0] <= bad_new; end
                  2'd1: begin staging1 <= hi_new; bad_flags[1] <= bad_new; end
                  2'd2: begin staging2 <= hi_new; bad_flags[2] <= bad_new; end
                  default: begin
                     duty0       <= staging0;
                     duty1       <= staging1;
                     duty2       <= staging2;
                     duty3       <= hi_new;
                     slot_err    <= bad_new | (|bad_flags);
                     frame_valid <= 1'b1;
                  end
               endcase
            end else begin
               hi_cnt    <= hi_new;
               zero_seen <= zero_base | ~pwm_in;
               bad       <= bad_new;
               p         <= cur_p + 4'd1;
               s         <= cur_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: hand-written frame table, corner-case sequences and
// random traffic, all checked cycle by cycle against a frame-level model.
module tb_pwm_decoder;

   localparam int L  = 4;
   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic          pwm_in;
   logic          sync;
   logic [CW-1:0] duty0, duty1, duty2, duty3;
   logic          frame_valid, slot_err, sync_err, locked;

   pwm_decoder #(.SLOT_LEN(L), .CW(CW)) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in), .sync(sync),
      .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
      .frame_valid(frame_valid), .slot_err(slot_err),
      .sync_err(sync_err), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Reference model: collect the samples of the current frame and
   // evaluate the whole frame once 4*L samples are in.
   int            q[$];
   logic [CW-1:0] mDuty [4];
   logic          mFv, mSlotErr, mSyncErr, mLocked;

   task automatic modelReset();
      q.delete();
      for (int k = 0; k < 4; k++) mDuty[k] = '0;
      mFv = 1'b0; mSlotErr = 1'b0; mSyncErr = 1'b0; mLocked = 1'b0;
   endtask

   task automatic modelStep(input logic pw, input logic sy);
      int ones;
      logic err;
      mFv = 1'b0;
      mSyncErr = 1'b0;
      if (sy) begin
         if (mLocked && q.size() != 0) mSyncErr = 1'b1;
         q.delete();
         mLocked = 1'b1;
      end
      if (mLocked) begin
         q.push_back(int'(pw));
         if (q.size() == 4 * L) begin
            err = 1'b0;
            for (int k = 0; k < 4; k++) begin
               ones = 0;
               for (int i = 0; i < L; i++) begin
                  ones += q[k*L + i];
                  for (int j = i + 1; j < L; j++)
                     if (q[k*L + i] == 0 && q[k*L + j] == 1) err = 1'b1;
               end
               mDuty[k] = CW'(ones);
            end
            mSlotErr = err;
            mFv = 1'b1;
            q.delete();
         end
      end
   endtask

   task automatic checkOutput(input string name);
      logic [4*CW+3:0] act, exp;
      act = {duty0, duty1, duty2, duty3, frame_valid, slot_err, sync_err, locked};
      exp = {mDuty[0], mDuty[1], mDuty[2], mDuty[3], mFv, mSlotErr, mSyncErr, mLocked};
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h expected %h (d0..d3,fv,serr,syncerr,lock)", name, act, exp);
      end
   endtask

   task automatic expectVal(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic pw, input logic sy, input string name);
      @(negedge clk);
      pwm_in = pw;
      sync   = sy;
      @(posedge clk);
      #1;
      modelStep(pw, sy);
      checkOutput(name);
   endtask

   typedef struct {
      logic [15:0] bits;
      logic        syncFirst;
      int          d0, d1, d2, d3;
      logic        err;
   } vec_t;

   vec_t vecs[7];
   vec_t v;
   int   fvCount, seCount;

   initial begin
      vecs[0] = '{16'b1000_1100_1110_1111, 1'b1, 1, 2, 3, 4, 1'b0};
      vecs[1] = '{16'b0000_0000_0000_0000, 1'b0, 0, 0, 0, 0, 1'b0};
      vecs[2] = '{16'b1111_1111_1111_1111, 1'b0, 4, 4, 4, 4, 1'b0};
      vecs[3] = '{16'b1000_0110_1000_1000, 1'b0, 1, 2, 1, 1, 1'b1};
      vecs[4] = '{16'b1000_1000_1000_1000, 1'b1, 1, 1, 1, 1, 1'b0};
      vecs[5] = '{16'b1100_0000_1111_0111, 1'b0, 2, 0, 4, 3, 1'b1};
      vecs[6] = '{16'b1110_1011_0001_1100, 1'b0, 3, 3, 1, 2, 1'b1};

      rst = 1'b1; pwm_in = 1'b0; sync = 1'b0;
      modelReset();
      #1;
      checkOutput("reset_state");
      @(negedge clk);
      rst = 1'b0;

      // Idle without sync: nothing should lock or emit
      for (int i = 0; i < 6; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, "idle");

      // Table frames, back to back; vector 4 carries an on-boundary sync
      for (int n = 0; n < 7; n++) begin
         v = vecs[n];
         for (int i = 0; i < 16; i++)
            applyStimulus(v.bits[15-i], (i == 0) && v.syncFirst, "table_cycle");
         expectVal("table_fv",   int'(frame_valid), 1);
         expectVal("table_d0",   int'(duty0), v.d0);
         expectVal("table_d1",   int'(duty1), v.d1);
         expectVal("table_d2",   int'(duty2), v.d2);
         expectVal("table_d3",   int'(duty3), v.d3);
         expectVal("table_serr", int'(slot_err), int'(v.err));
         expectVal("table_lock", int'(locked), 1);
         expectVal("table_syncerr", int'(sync_err), 0);
      end

      // Misaligned sync at slot 2 position 1
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, "mis_pre");
      applyStimulus(1'b1, 1'b1, "mis_sync");
      expectVal("mis_syncerr", int'(sync_err), 1);
      expectVal("mis_duty0_held", int'(duty0), vecs[6].d0);
      for (int i = 1; i < 16; i++) applyStimulus(1'(i < 2), 1'b0, "mis_post");
      expectVal("mis_fv_after", int'(frame_valid), 1);
      expectVal("mis_d0", int'(duty0), 2);
      applyStimulus(1'b0, 1'b0, "mis_tail");
      expectVal("mis_syncerr_clear", int'(sync_err), 0);

      // Sync landing on the very last sample of a frame discards it
      for (int i = 1; i < 15; i++) applyStimulus(1'b0, 1'b0, "last_pre");
      applyStimulus(1'b1, 1'b1, "last_sync");
      expectVal("last_fv", int'(frame_valid), 0);
      expectVal("last_syncerr", int'(sync_err), 1);

      // Reset mid-frame
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, "rst_pre");
      @(negedge clk);
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput("rst_async");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, "rst_nosync");
      for (int i = 0; i < 16; i++) applyStimulus(1'(i % 4 == 0), i == 0, "rst_relock");
      expectVal("rst_relock_fv", int'(frame_valid), 1);

      // Continuous frames with sync at every boundary
      fvCount = 0; seCount = 0;
      for (int i = 0; i < 64; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), (i % 16) == 0, "cont");
         if (frame_valid) fvCount++;
         if (sync_err) seCount++;
      end
      expectVal("cont_fv_count", fvCount, 4);
      expectVal("cont_syncerr_count", seCount, 0);

      // Random traffic with occasional stray syncs
      for (int i = 0; i < 400; i++)
         applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, "random");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
